// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_if
// Purpose  : Request, ALU and response bundle shared by the arbiter and users.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [2:0]       req0_f;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [2:0]       req1_f;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_f;
  logic [WIDTH-1:0] alu_y;
  logic             alu_zero;
  logic             alu_cout;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_y;
  logic             rsp_zero;
  logic             rsp_cout;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_f,
    input  req1_valid, req1_a, req1_b, req1_f,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_f,
    input  alu_y, alu_zero, alu_cout,
    output rsp_valid, rsp_id, rsp_y, rsp_zero, rsp_cout,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_f,
    output req1_valid, req1_a, req1_b, req1_f,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_f,
    output alu_y, alu_zero, alu_cout,
    input  rsp_valid, rsp_id, rsp_y, rsp_zero, rsp_cout,
    output rsp_ready
  );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Round-robin sharing of one combinational ALU between two users.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  wire              clk_i,
  input  wire              reset_i,
  alu_arbiter_if.slave     bus,
  output logic             busy_o,
  output logic [CNT_W-1:0] op_cnt0_o,
  output logic [CNT_W-1:0] op_cnt1_o
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_EXEC = 2'd1;
  localparam logic [1:0] c_RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             last_q, last_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       f_q, f_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             zero_q, zero_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic w_idle;
  logic w_win;
  logic w_accept;

  // On a tie the requester that did not win last time gets the ALU.
  assign w_idle   = (state_q == c_IDLE);
  assign w_win    = (bus.req0_valid & bus.req1_valid) ? ~last_q : bus.req1_valid;
  assign w_accept = w_idle & (bus.req0_valid | bus.req1_valid);

  assign bus.req0_ready = w_idle & bus.req0_valid & ~w_win;
  assign bus.req1_ready = w_idle & bus.req1_valid & w_win;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    f_d     = f_q;
    y_d     = y_q;
    zero_d  = zero_q;
    cout_d  = cout_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    case (state_q)
      c_IDLE: begin
        if (w_accept) begin
          state_d = c_EXEC;
          last_d  = w_win;
          id_d    = w_win;
          a_d     = w_win ? bus.req1_a : bus.req0_a;
          b_d     = w_win ? bus.req1_b : bus.req0_b;
          f_d     = w_win ? bus.req1_f : bus.req0_f;
        end
      end
      c_EXEC: begin
        y_d     = bus.alu_y;
        zero_d  = bus.alu_zero;
        cout_d  = bus.alu_cout;
        state_d = c_RESP;
      end
      c_RESP: begin
        if (bus.rsp_ready) begin
          state_d = c_IDLE;
          if (id_q) cnt1_d = cnt1_q + 1'b1;
          else      cnt0_d = cnt0_q + 1'b1;
        end
      end
      default: state_d = c_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= c_IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      f_q     <= '0;
      y_q     <= '0;
      zero_q  <= 1'b0;
      cout_q  <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      f_q     <= f_d;
      y_q     <= y_d;
      zero_q  <= zero_d;
      cout_q  <= cout_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_f     = f_q;
  assign bus.rsp_valid = (state_q == c_RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_y     = y_q;
  assign bus.rsp_zero  = zero_q;
  assign bus.rsp_cout  = cout_q;
  assign busy_o        = ~w_idle;
  assign op_cnt0_o     = cnt0_q;
  assign op_cnt1_o     = cnt1_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Randomised and directed scoreboard bench for alu_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
  localparam int WIDTH = 32;
  localparam int CNT_W = 8;

  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f;
    logic [31:0] y;
    logic        zero;
    logic        cout;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             busy;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
  logic [33:0]      alu_out;

  alu_arbiter_if #(.WIDTH(WIDTH)) bus ();

  alu_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk_i     (clk),
    .reset_i   (rst),
    .bus       (bus),
    .busy_o    (busy),
    .op_cnt0_o (cnt0),
    .op_cnt1_o (cnt1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int               checks = 0;
  int               errors = 0;
  exp_t             sbq[$];
  exp_t             resp_log[$];
  int               grant_log[$];
  int               acc_log[$];
  bit               inflight = 1'b0;
  int               acc_cyc = 0;
  bit               exp_last = 1'b1;
  logic [CNT_W-1:0] cnt_exp[2];
  int               comp_cnt = 0;
  bit               pend[2];
  logic [31:0]      pa[2];
  logic [31:0]      pb[2];
  logic [2:0]       pf[2];
  int               prob[2];
  int               rdy_prob = 100;
  bit               withdraw_en = 1'b0;

  // Stand-in ALU: {zero, cout, y}
  function automatic logic [33:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f);
    logic [32:0] s;
    logic [31:0] y;
    logic        c;
    s = '0;
    c = 1'b0;
    case (f)
      3'd0:    y = a & b;
      3'd1:    y = a | b;
      3'd2:    begin s = {1'b0, a} + {1'b0, b}; y = s[31:0]; c = s[32]; end
      3'd3:    y = a ^ b;
      3'd4:    y = a & ~b;
      3'd5:    y = a | ~b;
      3'd6:    begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; y = s[31:0]; c = s[32]; end
      default: y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
    return {(y == 32'd0), c, y};
  endfunction

  assign alu_out      = alu_ref(bus.alu_a, bus.alu_b, bus.alu_f);
  assign bus.alu_y    = alu_out[31:0];
  assign bus.alu_cout = alu_out[32];
  assign bus.alu_zero = alu_out[33];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endfunction

  task automatic drive();
    bus.req0_valid = pend[0];
    bus.req0_a     = pa[0];
    bus.req0_b     = pb[0];
    bus.req0_f     = pf[0];
    bus.req1_valid = pend[1];
    bus.req1_a     = pa[1];
    bus.req1_b     = pb[1];
    bus.req1_f     = pf[1];
  endtask

  task automatic post(input int r, input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
    pend[r] = 1'b1;
    pa[r]   = a;
    pb[r]   = b;
    pf[r]   = f;
  endtask

  function automatic void clear_model();
    sbq.delete();
    resp_log.delete();
    grant_log.delete();
    acc_log.delete();
    inflight   = 1'b0;
    exp_last   = 1'b1;
    cnt_exp[0] = '0;
    cnt_exp[1] = '0;
    comp_cnt   = 0;
    pend[0]    = 1'b0;
    pend[1]    = 1'b0;
  endfunction

  // Runs at +4 after the edge: readys must follow the round-robin rule, and
  // a handshake here lands at the coming edge.
  task automatic sample();
    int   w;
    exp_t e;
    if (inflight) begin
      chk("ready0_while_busy", bus.req0_ready, 0);
      chk("ready1_while_busy", bus.req1_ready, 0);
    end else begin
      w = -1;
      if (pend[0] && pend[1]) w = exp_last ? 0 : 1;
      else if (pend[0])       w = 0;
      else if (pend[1])       w = 1;
      chk("ready0", bus.req0_ready, (w == 0));
      chk("ready1", bus.req1_ready, (w == 1));
      if (w >= 0) begin
        e.id = (w == 1);
        e.a  = pa[w];
        e.b  = pb[w];
        e.f  = pf[w];
        {e.zero, e.cout, e.y} = alu_ref(pa[w], pb[w], pf[w]);
        sbq.push_back(e);
        inflight = 1'b1;
        acc_cyc  = cyc;
        exp_last = (w == 1);
        pend[w]  = 1'b0;
        grant_log.push_back(w);
        acc_log.push_back(cyc);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int r = 0; r < 2; r++) begin
      if (withdraw_en && pend[r] && inflight && ($urandom_range(15) == 0)) pend[r] = 1'b0;
      if (!pend[r] && ($urandom_range(99) < prob[r])) begin
        pend[r] = 1'b1;
        pa[r]   = ($urandom_range(3) == 0) ? 32'($urandom_range(7)) : $urandom;
        pb[r]   = ($urandom_range(3) == 0) ? 32'($urandom_range(7)) : $urandom;
        pf[r]   = 3'($urandom_range(7));
      end
    end
    bus.rsp_ready = ($urandom_range(99) < rdy_prob);
    drive();
    #3;
    sample();
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    clear_model();
    drive();
    #1;
    rst = 1'b0;
    #1;
    chk("rst_ready0", bus.req0_ready, 0);
    chk("rst_ready1", bus.req1_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_a", bus.alu_a, 0);
    chk("rst_alu_b", bus.alu_b, 0);
    chk("rst_alu_f", bus.alu_f, 0);
    chk("rst_rsp_y", bus.rsp_y, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_rsp_flags", {bus.rsp_zero, bus.rsp_cout}, 0);
    chk("rst_cnt0", cnt0, 0);
    chk("rst_cnt1", cnt1, 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    prob[0]  = 0;
    prob[1]  = 0;
    rdy_prob = 100;
    while ((inflight || pend[0] || pend[1]) && n < 50) begin
      step();
      n++;
    end
    chk("drain_timeout", (inflight || pend[0] || pend[1]), 0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT completes a response.
  initial begin : monitor
    bit   exp_rv;
    exp_t e;
    forever begin
      @(negedge clk);
      exp_rv = inflight && (cyc >= acc_cyc + 2);
      chk("rsp_valid", bus.rsp_valid, exp_rv);
      chk("busy", busy, (inflight && (cyc > acc_cyc)));
      chk("op_cnt0", cnt0, cnt_exp[0]);
      chk("op_cnt1", cnt1, cnt_exp[1]);
      if (inflight && (cyc > acc_cyc) && (sbq.size() > 0)) begin
        e = sbq[0];
        chk("alu_a", bus.alu_a, e.a);
        chk("alu_b", bus.alu_b, e.b);
        chk("alu_f", bus.alu_f, e.f);
      end
      if (bus.rsp_valid && exp_rv) begin
        if (sbq.size() == 0) begin
          chk("scoreboard_empty", 1, 0);
        end else begin
          e = sbq[0];
          chk("rsp_id", bus.rsp_id, e.id);
          chk("rsp_y", bus.rsp_y, e.y);
          chk("rsp_zero", bus.rsp_zero, e.zero);
          chk("rsp_cout", bus.rsp_cout, e.cout);
          if (bus.rsp_ready) begin
            void'(sbq.pop_front());
            resp_log.push_back(e);
            cnt_exp[e.id] = cnt_exp[e.id] + 1'b1;
            comp_cnt++;
            inflight = 1'b0;
          end
        end
      end
    end
  end

  initial begin : stim
    int n;
    int first_acc;
    int rv_cnt;
    bus.rsp_ready = 1'b0;
    prob[0] = 0;
    prob[1] = 0;
    clear_model();
    drive();
    pulse_reset();

    // Single op from req0: 5 + 3
    rdy_prob = 100;
    post(0, 32'd5, 32'd3, 3'b010);
    step();
    chk("t1_ready0", bus.req0_ready, 1);
    step();
    step();
    chk("t1_rsp_valid", bus.rsp_valid, 1);
    chk("t1_rsp_id", bus.rsp_id, 0);
    chk("t1_rsp_y", bus.rsp_y, 32'd8);
    chk("t1_rsp_zero", bus.rsp_zero, 0);
    step();
    chk("t1_cnt0", cnt0, 1);

    // Both requesters continuously valid
    pulse_reset();
    post(0, 32'd7, 32'd7, 3'b110);
    post(1, 32'd2, 32'd9, 3'b111);
    prob[0] = 100;
    prob[1] = 100;
    n = 0;
    while (comp_cnt < 6 && n < 60) begin
      step();
      n++;
    end
    chk("t2_cnt0", cnt0, 3);
    chk("t2_cnt1", cnt1, 3);
    drain();
    chk("t2_enough_grants", (grant_log.size() >= 6), 1);
    if (grant_log.size() >= 6) begin
      for (int i = 0; i < 6; i++) chk("t2_grant_order", grant_log[i], i % 2);
      for (int i = 1; i < 6; i++) chk("t2_accept_spacing", acc_log[i] - acc_log[i-1], 3);
    end
    chk("t2_enough_resps", (resp_log.size() >= 2), 1);
    if (resp_log.size() >= 2) begin
      chk("t2_r0_id", resp_log[0].id, 0);
      chk("t2_r0_y", resp_log[0].y, 0);
      chk("t2_r0_zero", resp_log[0].zero, 1);
      chk("t2_r1_id", resp_log[1].id, 1);
      chk("t2_r1_y", resp_log[1].y, 1);
    end

    // Backpressure: rsp_ready low for four RESP cycles
    pulse_reset();
    rdy_prob = 0;
    post(0, 32'h1234, 32'h10, 3'b010);
    step();
    first_acc = acc_cyc;
    post(1, 32'h40, 32'h2, 3'b110);
    step();
    rv_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      rv_cnt += int'(bus.rsp_valid);
    end
    rdy_prob = 100;
    step();
    rv_cnt += int'(bus.rsp_valid);
    step();
    chk("t3_rsp_valid_cycles", rv_cnt, 5);
    chk("t3_resume_cycle", acc_cyc - first_acc, 7);
    chk("t3_resume_grant", grant_log[grant_log.size()-1], 1);
    drain();

    // Reset during EXEC drops the op
    pulse_reset();
    post(0, 32'hDEAD_BEEF, 32'd1, 3'b010);
    step();
    pulse_reset();
    repeat (4) step();
    chk("t4_no_completion", comp_cnt, 0);
    post(1, 32'd4, 32'd5, 3'b010);
    drain();
    chk("t4_cnt1", cnt1, 1);
    chk("t4_cnt0", cnt0, 0);
    if (resp_log.size() > 0) chk("t4_y", bus.rsp_y, 32'd9);
    else chk("t4_resp_seen", 0, 1);

    // Counter wrap on requester 1
    pulse_reset();
    prob[1]  = 100;
    rdy_prob = 100;
    n = 0;
    while (comp_cnt < 255 && n < 900) begin
      if (comp_cnt == 254) prob[1] = 0;
      step();
      n++;
    end
    drain();
    chk("t5_cnt1_full", cnt1, 8'hFF);
    post(1, 32'd1, 32'd1, 3'b010);
    drain();
    chk("t5_cnt1_wrap", cnt1, 8'h00);
    chk("t5_cnt0", cnt0, 0);

    // Random traffic with backpressure and withdrawn requests
    pulse_reset();
    prob[0]     = 50;
    prob[1]     = 50;
    rdy_prob    = 70;
    withdraw_en = 1'b1;
    repeat (2000) step();
    withdraw_en = 1'b0;
    drain();
    chk("t6_sb_empty", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
